addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares a single saturating 16-bit add/sub datapath (`addsub_16bit`) between two requesters, e.g. the ALU issue path and the address/branch-target path. Requesters use a valid/ready handshake. A round-robin arbiter grants at most one per cycle. The saturated result is registered and returned on a response channel that the consumer can stall, with the winning requester's ID attached.

## Interface
- No parameters. Data width is fixed at 16 bits and the requester count is fixed at 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_a`, `req0_b`  in  16  signed operands, requester 0.
- `req0_sub`  in  1  1 = a−b, 0 = a+b, requester 0.
- `req0_ready`  out  1  requester 0 transfer accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_sub`, `req1_ready`  same as requester 0, for requester 1.
- `rsp_valid`  out  1  the response register holds a result.
- `rsp_ready`  in  1  the consumer takes the response this cycle.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_sum`  out  16  saturated signed result.
- `rsp_ovf`  out  1  result was clamped.
- `ops_cnt`  out  16  count of completed response transfers; wraps 0xFFFF→0x0000.

## Operation
- The block contains one `addsub_16bit` instance. Its operand mux is driven by the current grant.
- Saturation rules:
  - Positive overflow (a>0,b>0,add or a>0,b<0,sub with negative raw result) → 0x7FFF, `rsp_ovf`=1.
  - Negative overflow (a<0,b<0,add or a<0,b>0,sub with positive raw result) → 0x8000, `rsp_ovf`=1.
  - Otherwise → the 16-bit two's-complement raw result, `rsp_ovf`=0.
- Acceptance:
  - `can_accept` = ~`rsp_valid` | `rsp_ready`.
  - `reqN_ready` = `grantN` & `can_accept`.
  - At most one ready is asserted per cycle.
  - A transfer occurs when `reqN_valid`&`reqN_ready`.
- Round-robin arbitration:
  - A 1-bit `last` register holds the most recent transferred requester.
  - When both requesters are valid, the one ≠ `last` wins.
  - When exactly one is valid, it wins.
  - `last` updates only on a transfer.
- Response register:
  - On a transfer it loads {id, sum, ovf} and sets `rsp_valid`.
  - On a drain without a new transfer it clears `rsp_valid`.
  - On a simultaneous drain and transfer, the new result is loaded and `rsp_valid` stays 1.
- `ops_cnt` increments on each `rsp_valid`&`rsp_ready`.
- Requesters must hold their operands stable while valid and not ready. The block does not check this.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0x0000, `rsp_ovf`=0, `ops_cnt`=0, `last`=1 (so requester 0 wins first). `reqN_ready` is combinational; it is 0 whenever `rst`=1.
- `reqN_ready` is combinational from `reqN_valid`, `rsp_valid`, `rsp_ready` and `last`. There is no combinational path from operands to any output.
- Latency: a transfer at edge k makes the result visible on `rsp_*` after edge k. That is one cycle.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, both readies are 0 and the `rsp_*` outputs are held stable.
- Reset mid-operation: a pending response is discarded, `last` returns to 1, and `ops_cnt` clears. Reset overrides any same-cycle transfer or drain.

## Configuration
- `ADDSUB_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins when both are valid. The `last` register is not implemented, and requester 1 can starve.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both valids at 1. Required: both readies 0, `rsp_valid`=0, `rsp_sum`=0x0000, `ops_cnt`=0.
- Add overflow: req0 a=0x7000, b=0x2000, sub=0, `rsp_ready`=1. Required: next cycle `rsp_valid`=1, id=0, sum=0x7FFF, ovf=1, then `ops_cnt`=1.
- Sub cases on req1:
  - a=0x8000, b=0x0001, sub=1 → sum=0x8000, ovf=1.
  - a=0x0005, b=0x0003, sub=1 → sum=0x0002, ovf=0.
- Contention: both valid for 6 cycles, `rsp_ready`=1. Required: `rsp_id` sequence 0,1,0,1,0,1 (with the macro defined: 0,0,0,0,0,0), and `ops_cnt`=6.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with a response pending. Required: readies 0 and `rsp_*` unchanged. Then raise `rsp_ready`=1: a new transfer completes in the same cycle and `rsp_valid` stays 1.
- Reset mid-stream: assert `rst` during continuous traffic. Required: next cycle `rsp_valid`=0 and `ops_cnt`=0. After deassert, the first grant goes to req0.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two requesters share one saturating 16-bit add/sub unit through a round-robin arbiter.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).

module addsub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovf
);
  logic [16:0] ext;

  // A 17-bit sign-extended result exposes signed overflow as a top-two-bit disagreement.
  always_comb begin
    if (sub) begin
      ext = {a[15], a} - {b[15], b};
    end else begin
      ext = {a[15], a} + {b[15], b};
    end
    ovf = ext[16] ^ ext[15];
    if (!ovf) begin
      sum = ext[15:0];
    end else if (ext[16]) begin
      sum = 16'h8000;
    end else begin
      sum = 16'h7FFF;
    end
  end
endmodule

module addsub_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_sub,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_sub,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_ovf,
  output logic [15:0] ops_cnt
);
  logic        grant0;
  logic        grant1;
  logic        can_accept;
  logic        xfer;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic [15:0] alu_sum;
  logic        alu_ovf;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic [15:0] ops_cnt_q, ops_cnt_d;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
`else
  logic last_q, last_d;

  // Requester 0 wins when alone, or when both are valid and requester 1 went last.
  assign grant0 = req0_valid & (~req1_valid | last_q);
`endif
  assign grant1 = req1_valid & ~grant0;

  assign can_accept = ~rsp_valid_q | rsp_ready;
  assign req0_ready = grant0 & can_accept & ~rst;
  assign req1_ready = grant1 & can_accept & ~rst;
  assign xfer       = req0_ready | req1_ready;

  assign op_a   = grant1 ? req1_a   : req0_a;
  assign op_b   = grant1 ? req1_b   : req0_b;
  assign op_sub = grant1 ? req1_sub : req0_sub;

  addsub_16bit u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .sum (alu_sum),
    .ovf (alu_ovf)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    ops_cnt_d   = ops_cnt_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant1;
      rsp_sum_d   = alu_sum;
      rsp_ovf_d   = alu_ovf;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (rsp_valid_q && rsp_ready) begin
      ops_cnt_d = ops_cnt_q + 16'd1;
    end
  end

`ifndef ADDSUB_ARB_FIXED_PRIO_EN
  assign last_d = xfer ? grant1 : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= 16'h0000;
      rsp_ovf_q   <= 1'b0;
      ops_cnt_q   <= 16'h0000;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign ops_cnt   = ops_cnt_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: reset, saturation, arbitration, backpressure, mid-stream reset.
// Build with ADDSUB_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.

module tb_addsub_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_sub, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_sub, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [15:0] rsp_sum, ops_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_ovf    (rsp_ovf),
    .ops_cnt    (ops_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [15:0] sum, input logic ovf);
    check({tag, ".valid"}, {15'd0, rsp_valid}, {15'd0, v});
    check({tag, ".id"},    {15'd0, rsp_id},    {15'd0, id});
    check({tag, ".sum"},   rsp_sum, sum);
    check({tag, ".ovf"},   {15'd0, rsp_ovf},   {15'd0, ovf});
    $display("txn %-10s valid=%0b id=%0b sum=%h ovf=%0b ops_cnt=%0d",
             tag, rsp_valid, rsp_id, rsp_sum, rsp_ovf, ops_cnt);
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, ".rdy0"}, {15'd0, req0_ready}, {15'd0, r0});
    check({tag, ".rdy1"}, {15'd0, req1_ready}, {15'd0, r1});
  endtask

  initial begin
    logic exp_id;
    logic [15:0] exp_sum;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_sub = 1'b0;

    // Reset with both valids high.
    @(negedge clk); @(negedge clk);
    check_rdy("reset", 1'b0, 1'b0);
    check_rsp("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    check("reset.ops", ops_cnt, 16'd0);

    // Positive add overflow on req0.
    rst = 1'b0;
    req1_valid = 1'b0;
    req0_a = 16'h7000; req0_b = 16'h2000; req0_sub = 1'b0;
    #1 check_rdy("addovf", 1'b1, 1'b0);
    @(negedge clk);
    check_rsp("addovf", 1'b1, 1'b0, 16'h7FFF, 1'b1);
    check("addovf.ops0", ops_cnt, 16'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("addovf.drain", {15'd0, rsp_valid}, 16'd0);
    check("addovf.ops1", ops_cnt, 16'd1);

    // Subtract cases on req1, back to back.
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h0001; req1_sub = 1'b1;
    #1 check_rdy("subneg", 1'b0, 1'b1);
    @(negedge clk);
    check_rsp("subneg", 1'b1, 1'b1, 16'h8000, 1'b1);
    req1_a = 16'h0005; req1_b = 16'h0003;
    @(negedge clk);
    check_rsp("subnorm", 1'b1, 1'b1, 16'h0002, 1'b0);
    check("subnorm.ops", ops_cnt, 16'd2);
    req1_valid = 1'b0;
    @(negedge clk);
    check("sub.drain", {15'd0, rsp_valid}, 16'd0);
    check("sub.ops", ops_cnt, 16'd3);

    // Contention: req0 computes 1+1=2, req1 computes 10-3=7.
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h000A; req1_b = 16'h0003; req1_sub = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      exp_sum = exp_id ? 16'h0007 : 16'h0002;
      check_rsp($sformatf("cont%0d", i), 1'b1, exp_id, exp_sum, 1'b0);
      check($sformatf("cont%0d.ops", i), ops_cnt, 16'(3 + i));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("cont.ops", ops_cnt, 16'd9);

    // Backpressure: response 0x1234+0x0111 held while consumer stalls.
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0111; req0_sub = 1'b0;
    @(negedge clk);
    check_rsp("bp.load", 1'b1, 1'b0, 16'h1345, 1'b0);
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0100; req1_b = 16'h0001; req1_sub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      @(negedge clk);
      check_rsp($sformatf("bp%0d", i), 1'b1, 1'b0, 16'h1345, 1'b0);
      check($sformatf("bp%0d.ops", i), ops_cnt, 16'd9);
    end
    rsp_ready = 1'b1;
    #1 check_rdy("bp.rel", 1'b0, 1'b1);
    @(negedge clk);
    check_rsp("bp.rel", 1'b1, 1'b1, 16'h00FF, 1'b0);
    check("bp.rel.ops", ops_cnt, 16'd10);

    // Reset mid-stream: after a req0 grant, reset must make req0 first again.
    req0_valid = 1'b1; req0_a = 16'h0002; req0_b = 16'h0003; req0_sub = 1'b0;
    @(negedge clk);
    check_rsp("mid.pre", 1'b1, 1'b0, 16'h0005, 1'b0);
    rst = 1'b1;
    #1 check_rdy("mid.rst", 1'b0, 1'b0);
    @(negedge clk);
    check("mid.valid", {15'd0, rsp_valid}, 16'd0);
    check("mid.ops", ops_cnt, 16'd0);
    rst = 1'b0;
    #1 check_rdy("mid.post", 1'b1, 1'b0);
    @(negedge clk);
    check_rsp("mid.post", 1'b1, 1'b0, 16'h0005, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
